// File: rtl/flash_burst_read_fsm.sv
// Avalon-MM burst read master: issues one BURST_LEN-word read per start pulse,
// strobes each returned word, and aborts with timeout_err if the flash stalls.
module flash_burst_read_fsm #(
  parameter int unsigned ADDR_W    = 23,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BC_W      = 4,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned TO_W      = 8,
  parameter int unsigned TIMEOUT   = 200
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] address_in,
  input  logic              flash_waitrequest,
  input  logic              flash_readdatavalid,
  input  logic [DATA_W-1:0] flash_readdata,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  output logic [BC_W-1:0]   flash_burstcount,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [BC_W-1:0]   beat_index,
  output logic              busy,
  output logic              finish,
  output logic              timeout_err,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_REQUEST = 3'b001,
    S_COLLECT = 3'b010,
    S_DONE    = 3'b011,
    S_ABORT   = 3'b100
  } state_e;

  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BURST_LEN - 1);
  localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [BC_W-1:0]     bidx_q, bidx_d;
  logic [BC_W-1:0]     beat_q, beat_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                read_q, read_d;
  logic                dv_q, dv_d;
  logic                busy_q, busy_d;
  logic                fin_q, fin_d;
  logic                terr_q, terr_d;

  // Next-state and registered-output logic; progress always beats timeout.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    bidx_d  = bidx_q;
    beat_d  = beat_q;
    to_d    = to_q;
    dv_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = address_in;
          beat_d  = '0;
          to_d    = '0;
          state_d = S_REQUEST;
        end
      end
      S_REQUEST: begin
        if (!flash_waitrequest) begin
          to_d    = '0;
          state_d = S_COLLECT;
        end else if (to_q == TO_LIMIT) begin
          state_d = S_ABORT;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_COLLECT: begin
        if (flash_readdatavalid) begin
          data_d = flash_readdata;
          dv_d   = 1'b1;
          bidx_d = beat_q;
          beat_d = beat_q + BC_W'(1);
          to_d   = '0;
          if (beat_q == LAST_BEAT) state_d = S_DONE;
        end else if (to_q == TO_LIMIT) begin
          state_d = S_ABORT;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    read_d = (state_d == S_REQUEST);
    busy_d = (state_d != S_IDLE);
    fin_d  = (state_d == S_DONE) || (state_d == S_ABORT);
    terr_d = (state_d == S_ABORT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      bidx_q  <= '0;
      beat_q  <= '0;
      to_q    <= '0;
      read_q  <= 1'b0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      bidx_q  <= bidx_d;
      beat_q  <= beat_d;
      to_q    <= to_d;
      read_q  <= read_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      terr_q  <= terr_d;
    end
  end

  assign flash_read       = read_q;
  assign flash_address    = addr_q;
  assign flash_burstcount = BC_W'(BURST_LEN);
  assign data_out         = data_q;
  assign data_valid       = dv_q;
  assign beat_index       = bidx_q;
  assign busy             = busy_q;
  assign finish           = fin_q;
  assign timeout_err      = terr_q;
  assign state            = state_q;

endmodule

// File: tb/tb_flash_burst_read_fsm.sv
// Bench for flash_burst_read_fsm: a 4-word and a 1-word instance driven by a
// scripted flash slave, checked against a transaction-level expectation model.
module tb_flash_burst_read_fsm;

  localparam int unsigned AW = 23;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned TW = 8;
  localparam int          TO = 10;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start_a, start_b;
  logic [AW-1:0] address_in;
  logic          waitreq, rdvalid;
  logic [DW-1:0] rdata;

  logic          a_read, a_dv, a_busy, a_fin, a_terr;
  logic [AW-1:0] a_addr;
  logic [BW-1:0] a_bc, a_bi;
  logic [DW-1:0] a_data;
  logic [2:0]    a_state;
  logic          b_read, b_dv, b_busy, b_fin, b_terr;
  logic [AW-1:0] b_addr;
  logic [BW-1:0] b_bc, b_bi;
  logic [DW-1:0] b_data;
  logic [2:0]    b_state;

  logic          sel;
  logic          o_read, o_dv, o_busy, o_fin, o_terr;
  logic [AW-1:0] o_addr;
  logic [BW-1:0] o_bc, o_bi;
  logic [DW-1:0] o_data;
  logic [2:0]    o_state;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_data [2];
  logic [BW-1:0] exp_bi   [2];

  always #5 clock = ~clock;

  flash_burst_read_fsm #(
    .ADDR_W(AW), .DATA_W(DW), .BC_W(BW), .BURST_LEN(4), .TO_W(TW), .TIMEOUT(TO)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .address_in(address_in),
    .flash_waitrequest(waitreq), .flash_readdatavalid(rdvalid), .flash_readdata(rdata),
    .flash_read(a_read), .flash_address(a_addr), .flash_burstcount(a_bc),
    .data_out(a_data), .data_valid(a_dv), .beat_index(a_bi), .busy(a_busy),
    .finish(a_fin), .timeout_err(a_terr), .state(a_state)
  );

  flash_burst_read_fsm #(
    .ADDR_W(AW), .DATA_W(DW), .BC_W(BW), .BURST_LEN(1), .TO_W(TW), .TIMEOUT(TO)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .address_in(address_in),
    .flash_waitrequest(waitreq), .flash_readdatavalid(rdvalid), .flash_readdata(rdata),
    .flash_read(b_read), .flash_address(b_addr), .flash_burstcount(b_bc),
    .data_out(b_data), .data_valid(b_dv), .beat_index(b_bi), .busy(b_busy),
    .finish(b_fin), .timeout_err(b_terr), .state(b_state)
  );

  always_comb begin
    o_read  = sel ? b_read  : a_read;
    o_dv    = sel ? b_dv    : a_dv;
    o_busy  = sel ? b_busy  : a_busy;
    o_fin   = sel ? b_fin   : a_fin;
    o_terr  = sel ? b_terr  : a_terr;
    o_addr  = sel ? b_addr  : a_addr;
    o_bc    = sel ? b_bc    : a_bc;
    o_bi    = sel ? b_bi    : a_bi;
    o_data  = sel ? b_data  : a_data;
    o_state = sel ? b_state : a_state;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    start_a = sel ? 1'b0 : v;
    start_b = sel ? v : 1'b0;
  endtask

  // One IDLE cycle: everything quiet, data/index holding, stray valid ignored.
  task automatic idle_cycle();
    int k = int'(sel);
    @(negedge clock);
    chk("idle_state", 64'(o_state), 64'(0));
    chk("idle_busy",  64'(o_busy),  64'(0));
    chk("idle_read",  64'(o_read),  64'(0));
    chk("idle_fin",   64'(o_fin),   64'(0));
    chk("idle_dv",    64'(o_dv),    64'(0));
    chk("idle_data",  64'(o_data),  64'(exp_data[k]));
    chk("idle_bi",    64'(o_bi),    64'(exp_bi[k]));
    drive_start(1'b0);
    waitreq = 1'($urandom);
    rdvalid = 1'b1;
    rdata   = $urandom;
  endtask

  // One burst on instance 'which'. stall = waitrequest-high cycles, gaps between
  // beats drawn from [gmin,gmax], n_deliver = beats the slave returns at all,
  // rst_at > 0 pulls reset right after that many beats were captured.
  task automatic run_burst(input bit which, input logic [AW-1:0] addr, input int stall,
                           input int gmin, input int gmax, input int n_deliver,
                           input bit mid_start, input int rst_at);
    int k, bl, reqc, exp_state, idle, got, gap, guard;
    bit abort_req, exp_dv, v;
    logic [DW-1:0] d;
    sel = which;
    k   = int'(which);
    bl  = which ? 1 : 4;

    @(negedge clock);
    chk("pre_state", 64'(o_state), 64'(0));
    chk("pre_busy",  64'(o_busy),  64'(0));
    chk("pre_dv",    64'(o_dv),    64'(0));
    chk("pre_data",  64'(o_data),  64'(exp_data[k]));
    drive_start(1'b1);
    address_in = addr;
    waitreq    = 1'($urandom);
    rdvalid    = 1'b1;
    rdata      = $urandom;

    abort_req = (stall > TO);
    reqc      = abort_req ? TO + 1 : stall + 1;
    for (int i = 0; i < reqc; i++) begin
      @(negedge clock);
      chk("req_state", 64'(o_state), 64'(1));
      chk("req_read",  64'(o_read),  64'(1));
      chk("req_addr",  64'(o_addr),  64'(addr));
      chk("req_bc",    64'(o_bc),    64'(bl));
      chk("req_busy",  64'(o_busy),  64'(1));
      chk("req_fin",   64'(o_fin),   64'(0));
      chk("req_dv",    64'(o_dv),    64'(0));
      drive_start(1'($urandom));
      address_in = AW'($urandom);
      waitreq    = (i < stall);
      rdvalid    = 1'($urandom);
      rdata      = $urandom;
    end

    exp_state = abort_req ? 4 : 2;
    exp_dv    = 1'b0;
    idle      = 0;
    got       = 0;
    guard     = 0;
    gap       = $urandom_range(gmax, gmin);
    forever begin
      @(negedge clock);
      chk("col_state", 64'(o_state), 64'(exp_state));
      chk("col_dv",    64'(o_dv),    64'(exp_dv));
      chk("col_data",  64'(o_data),  64'(exp_data[k]));
      chk("col_bi",    64'(o_bi),    64'(exp_bi[k]));
      chk("col_fin",   64'(o_fin),   64'(exp_state >= 3));
      chk("col_terr",  64'(o_terr),  64'(exp_state == 4));
      chk("col_read",  64'(o_read),  64'(0));
      chk("col_busy",  64'(o_busy),  64'(1));
      if (rst_at > 0 && got == rst_at) begin
        reset_n = 1'b0;
        drive_start(1'b0);
        rdvalid = 1'b1;
        rdata   = $urandom;
        #1;
        chk("rst_state", 64'(o_state), 64'(0));
        chk("rst_read",  64'(o_read),  64'(0));
        chk("rst_addr",  64'(o_addr),  64'(0));
        chk("rst_data",  64'(o_data),  64'(0));
        chk("rst_dv",    64'(o_dv),    64'(0));
        chk("rst_bi",    64'(o_bi),    64'(0));
        chk("rst_fin",   64'(o_fin),   64'(0));
        chk("rst_terr",  64'(o_terr),  64'(0));
        chk("rst_busy",  64'(o_busy),  64'(0));
        exp_data[0] = '0; exp_data[1] = '0;
        exp_bi[0]   = '0; exp_bi[1]   = '0;
        @(negedge clock);
        reset_n = 1'b1;
        rdvalid = 1'b1;
        rdata   = $urandom;
        return;
      end
      if (exp_state != 2) break;
      if (++guard > 300) begin
        tests++;
        fails++;
        $error("FAIL col_bound observed=%0d expected=<300 cycles", guard);
        break;
      end
      drive_start(mid_start);
      waitreq = 1'b0;
      v       = (got < n_deliver) && (gap == 0);
      d       = $urandom;
      rdvalid = v;
      rdata   = d;
      if (v) begin
        exp_data[k] = d;
        exp_bi[k]   = BW'(got);
        exp_dv      = 1'b1;
        got++;
        idle        = 0;
        exp_state   = (got == bl) ? 3 : 2;
        gap         = $urandom_range(gmax, gmin);
      end else begin
        exp_dv = 1'b0;
        if (idle == TO) exp_state = 4;
        else idle++;
        if (gap > 0) gap--;
      end
    end
    drive_start(mid_start);
    rdvalid = 1'b1;
    rdata   = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, st, gm, nd, bl;
    reset_n    = 1'b0;
    sel        = 1'b0;
    start_a    = 1'b0;
    start_b    = 1'b0;
    address_in = '0;
    waitreq    = 1'b0;
    rdvalid    = 1'b0;
    rdata      = '0;
    exp_data[0] = '0; exp_data[1] = '0;
    exp_bi[0]   = '0; exp_bi[1]   = '0;
    #2;
    chk("init_state", 64'(o_state), 64'(0));
    chk("init_read",  64'(o_read),  64'(0));
    chk("init_addr",  64'(o_addr),  64'(0));
    chk("init_data",  64'(o_data),  64'(0));
    chk("init_dv",    64'(o_dv),    64'(0));
    chk("init_bi",    64'(o_bi),    64'(0));
    chk("init_fin",   64'(o_fin),   64'(0));
    chk("init_terr",  64'(o_terr),  64'(0));
    chk("init_busy",  64'(o_busy),  64'(0));
    chk("init_bc_a",  64'(o_bc),    64'(4));
    sel = 1'b1;
    #1;
    chk("init_bc_b",  64'(o_bc),    64'(1));
    sel = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    run_burst(1'b0, 23'h000100, 0, 0, 0, 4, 1'b0, 0);   // basic
    idle_cycle();
    run_burst(1'b0, 23'h012345, 5, 0, 0, 4, 1'b0, 0);   // waitrequest stall
    idle_cycle();
    run_burst(1'b0, 23'h7ABCDE, 1, 3, 3, 4, 1'b1, 0);   // gapped data, start while busy
    idle_cycle();
    idle_cycle();
    run_burst(1'b0, 23'h000200, 0, 0, 1, 2, 1'b0, 0);   // data timeout after beat 1
    idle_cycle();
    run_burst(1'b0, 23'h000300, TO + 1, 0, 0, 4, 1'b0, 0); // command never accepted
    idle_cycle();
    run_burst(1'b0, 23'h000400, TO, TO, TO, 4, 1'b0, 0);   // waits exactly at the limit
    idle_cycle();
    run_burst(1'b0, 23'h000500, 2, 0, 2, 4, 1'b0, 2);   // reset after beat 1
    idle_cycle();
    run_burst(1'b0, 23'h000600, 0, 0, 0, 4, 1'b0, 0);   // clean burst after reset
    run_burst(1'b1, 23'h001000, 0, 0, 0, 1, 1'b0, 0);   // single-word back-to-back
    run_burst(1'b1, 23'h001001, 1, 0, 0, 1, 1'b0, 0);
    run_burst(1'b1, 23'h001002, 0, 2, 2, 1, 1'b1, 0);
    idle_cycle();

    for (int n = 0; n < 30; n++) begin
      w  = int'($urandom_range(1, 0));
      bl = (w != 0) ? 1 : 4;
      st = ($urandom_range(4, 0) == 0) ? int'($urandom_range(12, 8)) : int'($urandom_range(3, 0));
      gm = ($urandom_range(5, 0) == 0) ? 12 : 3;
      nd = ($urandom_range(3, 0) == 0) ? int'($urandom_range(bl, 0)) : bl;
      run_burst(1'(w), AW'($urandom), st, 0, gm, nd, 1'($urandom), 0);
      if ($urandom_range(1, 0) == 1) idle_cycle();
    end
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/flash_burst_read_fsm.md
Name: flash_burst_read_fsm

Overview:
- Parametrised Avalon-MM read master for the flash audio path; successor to the single-word flash read timer FSM.
- Sits between the sample-fetch controller and the flash controller.
- On a start pulse it issues one burst read of BURST_LEN words and presents each returned word with a strobe.
- Signals completion with a finish pulse, or a timeout error if the flash controller stalls.

Parameters:
- ADDR_W, 23, flash word-address width
- DATA_W, 32, flash read-data width
- BC_W, 4, burstcount width
- BURST_LEN, 4, words per burst; legal range 1..2^BC_W-1
- TO_W, 8, timeout counter width
- TIMEOUT, 200, maximum idle cycles with no progress before abort; legal range 1..2^TO_W-1

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request a burst; sampled only in IDLE
- address_in  in  ADDR_W  burst start address, latched with start
- flash_waitrequest  in  1  Avalon waitrequest
- flash_readdatavalid  in  1  Avalon readdatavalid
- flash_readdata  in  DATA_W  Avalon readdata
- flash_read  out  1  Avalon read command
- flash_address  out  ADDR_W  Avalon address, held stable while flash_read=1
- flash_burstcount  out  BC_W  constant BURST_LEN
- data_out  out  DATA_W  last captured word
- data_valid  out  1  one-cycle strobe per captured word
- beat_index  out  BC_W  index (0..BURST_LEN-1) of word in data_out
- busy  out  1  high in every state except IDLE
- finish  out  1  one-cycle pulse at end of burst (normal or aborted)
- timeout_err  out  1  one-cycle pulse coincident with finish on abort
- state  out  3  current state encoding, for debug

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; flash_read=0; flash_address=0; data_out=0; data_valid=0; beat_index=0; finish=0; timeout_err=0.
  - Beat and timeout counters cleared.
  - Reset asserted mid-burst aborts immediately. No finish pulse is produced. Any outstanding readdatavalid beats after reset release are ignored, because they arrive in IDLE.
- States: IDLE=000, REQUEST=001, COLLECT=010, DONE=011, ABORT=100. Other encodings go to IDLE.
- IDLE:
  - When start=1, latch address_in into flash_address, clear counters, and go to REQUEST.
  - flash_read=1 from the first REQUEST cycle. Latency start->flash_read is 1 cycle.
- REQUEST:
  - flash_read=1.
  - At an edge where flash_waitrequest=0, the command is accepted: go to COLLECT, flash_read=0 next cycle, timeout counter cleared.
  - While waitrequest=1, the timeout counter increments.
- COLLECT:
  - Each edge with flash_readdatavalid=1: data_out<=flash_readdata, data_valid=1 for the next cycle, beat_index<=beat count, beat count+1, timeout counter cleared.
  - The beat with index BURST_LEN-1 moves the FSM to DONE.
  - Cycles without valid increment the timeout counter.
- readdatavalid is ignored in IDLE, REQUEST, DONE and ABORT. It is never captured in the acceptance cycle.
- Timeout:
  - In REQUEST or COLLECT, when the counter equals TIMEOUT and no progress occurs on that edge, go to ABORT and drop flash_read.
  - Progress on the same edge (accept or beat) has priority over timeout.
- DONE: finish=1 for exactly one cycle, then IDLE.
- ABORT: finish=1 and timeout_err=1 for exactly one cycle, then IDLE.
- data_valid and the last data_valid are both visible in the DONE cycle: the final word is strobed in the same cycle as finish.
- start while busy=1, including in DONE/ABORT, is ignored and is not queued. A new burst can start from IDLE the cycle after finish; back-to-back gap is 1 IDLE cycle.
- address_in changes after the start edge do not affect flash_address.
- busy is registered as state!=IDLE.

Test Plan:
- Basic: BURST_LEN=4, start with address_in=0x000100, waitrequest low on first REQUEST cycle, valid on 4 consecutive cycles with data 0xA0..0xA3 -> flash_read high exactly 1 cycle, flash_address=0x000100, burstcount=4, data_valid x4 with beat_index 0..3, finish 1 cycle with last strobe, timeout_err=0.
- Waitrequest stall: waitrequest held high 5 cycles -> flash_read high 6 cycles, address stable, then normal collection and finish.
- Gapped data with start mid-burst: valid beats separated by 3 idle cycles, start pulsed during COLLECT -> all 4 words captured in order, no second burst issued.
- Timeout: TIMEOUT=10, accept command, deliver 2 beats then none -> ABORT after 10 idle cycles past beat 1, finish=1 and timeout_err=1 same cycle, flash_read=0.
- Reset mid-burst: reset_n low during COLLECT after beat 1 -> all outputs 0 asynchronously, no finish. A late valid after release is not captured. A subsequent start runs a clean burst.
- Single-word mode: BURST_LEN=1, back-to-back starts on cycle after finish -> each burst has burstcount=1, one strobe, finish; 1-cycle IDLE gap between bursts.
